// File: rtl/avr_core_pkg.sv
// Shared core definitions: I/O addresses of the stack pointer and status
// register, SREG bit positions, and the stack sequencer state/direction
// encodings. Also used by the I/O read multiplexer.
package avr_core_pkg;

  localparam logic [5:0] SPL_ADR  = 6'h3D;
  localparam logic [5:0] SPH_ADR  = 6'h3E;
  localparam logic [5:0] SREG_ADR = 6'h3F;

  localparam int SREG_C = 0;
  localparam int SREG_Z = 1;
  localparam int SREG_N = 2;
  localparam int SREG_V = 3;
  localparam int SREG_S = 4;
  localparam int SREG_H = 5;
  localparam int SREG_T = 6;
  localparam int SREG_I = 7;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } stk_state_t;

  typedef enum logic {
    PUSH = 1'b0,
    POP  = 1'b1
  } stk_dir_t;

endpackage

// File: rtl/sp_sreg_unit_stk_seq.sv
// stk_seq: stack transfer sequencer. Accepts a 1..3 byte request in IDLE,
// counts accepted bytes in RUN and raises a registered one-cycle done pulse
// after the last byte. It only issues SP step enables; the SP register
// itself lives in the parent.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start, dir, len request (sampled in IDLE only; len 0 is a no-op)
//   step            memory accepted the current byte
//   busy            sequence in progress (from state only)
//   done            one-cycle pulse after the last byte
//   dir_q           latched direction of the running sequence
//   sp_inc, sp_dec  SP step enables for pop / push
module stk_seq
  import avr_core_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dir,
  input  logic [1:0] len,
  input  logic       step,
  output logic       busy,
  output logic       done,
  output stk_dir_t   dir_q,
  output logic       sp_inc,
  output logic       sp_dec
);

  stk_state_t state_q, state_n;
  logic [1:0] cnt_q, cnt_n;
  stk_dir_t   dir_n;
  logic       done_n;
  logic       step_en;

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    dir_n   = dir_q;
    done_n  = 1'b0;
    step_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && (len != 2'd0)) begin
          state_n = RUN;
          cnt_n   = len;
          dir_n   = stk_dir_t'(dir);
        end
      end
      RUN: begin
        if (step) begin
          step_en = 1'b1;
          cnt_n   = cnt_q - 2'd1;
          if (cnt_q == 2'd1) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Done is registered so neither busy nor done has a path from step.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      done    <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      done    <= done_n;
    end
    dir_q <= dir_n;
  end

  assign busy   = (state_q == RUN);
  assign sp_inc = step_en && (dir_q == POP);
  assign sp_dec = step_en && (dir_q == PUSH);

endmodule

// File: rtl/sp_sreg_unit.sv
// sp_sreg_unit: architectural Stack Pointer (SPL/SPH) and Status Register.
// Services OUT writes to 0x3D/0x3E/0x3F, sequences multi-byte stack
// transfers through stk_seq, and applies ALU flag and I-flag updates.
// Ports:
//   cp2, ireset                      clock, synchronous active-high reset
//   adr, iowe, dbusout               I/O write interface
//   stk_start/dir/len/step           stack request and byte handshake
//   stk_busy, stk_adr, stk_done      stack status and byte address
//   sreg_fl_in, sreg_fl_wr           per-bit flag updates
//   irq_ent, reti_ex                 I flag clear / set
//   spl_out, sph_out, sreg_out       register values for the IN read mux
module sp_sreg_unit
  import avr_core_pkg::*;
#(
  parameter int                  SP_WIDTH = 12,
  parameter logic [SP_WIDTH-1:0] SP_RST   = 12'h8FF,
  parameter logic [7:0]          SREG_RST = 8'h00
) (
  input  logic        cp2,
  input  logic        ireset,
  input  logic [5:0]  adr,
  input  logic        iowe,
  input  logic [7:0]  dbusout,
  input  logic        stk_start,
  input  logic        stk_dir,
  input  logic [1:0]  stk_len,
  input  logic        stk_step,
  output logic        stk_busy,
  output logic [15:0] stk_adr,
  output logic        stk_done,
  input  logic [7:0]  sreg_fl_in,
  input  logic [7:0]  sreg_fl_wr,
  input  logic        irq_ent,
  input  logic        reti_ex,
  output logic [7:0]  spl_out,
  output logic [7:0]  sph_out,
  output logic [7:0]  sreg_out
);

  localparam logic [SP_WIDTH-1:0] SP_ONE = 1;

  logic [SP_WIDTH-1:0] sp_q, sp_n, sp_plus;
  logic [7:0]          sreg_q, sreg_n;
  logic [15:0]         sp_ext;
  stk_dir_t            dir_q;
  logic                sp_inc, sp_dec;

  stk_seq u_stk_seq (
    .clk    (cp2),
    .rst    (ireset),
    .start  (stk_start),
    .dir    (stk_dir),
    .len    (stk_len),
    .step   (stk_step),
    .busy   (stk_busy),
    .done   (stk_done),
    .dir_q  (dir_q),
    .sp_inc (sp_inc),
    .sp_dec (sp_dec)
  );

  assign sp_plus = sp_q + SP_ONE;

  // Pop pre-increments, so its byte sits one above SP; wraps with SP width.
  always_comb begin
    stk_adr = '0;
    stk_adr[SP_WIDTH-1:0] = (stk_busy && (dir_q == POP)) ? sp_plus : sp_q;
  end

  // An I/O write to either SP byte wins over a concurrent step: the written
  // byte loads, the other keeps its pre-step value.
  always_comb begin
    sp_n = sp_q;
    if (sp_inc)      sp_n = sp_plus;
    else if (sp_dec) sp_n = sp_q - SP_ONE;
    if (iowe && (adr == SPL_ADR)) begin
      sp_n      = sp_q;
      sp_n[7:0] = dbusout;
    end else if (iowe && (adr == SPH_ADR)) begin
      sp_n                 = sp_q;
      sp_n[SP_WIDTH-1:8]   = dbusout[SP_WIDTH-9:0];
    end
  end

  // Later assignments win: flags < RETI set < IRQ clear < full write.
  always_comb begin
    sreg_n = (sreg_q & ~sreg_fl_wr) | (sreg_fl_in & sreg_fl_wr);
    if (reti_ex) sreg_n[SREG_I] = 1'b1;
    if (irq_ent) sreg_n[SREG_I] = 1'b0;
    if (iowe && (adr == SREG_ADR)) sreg_n = dbusout;
  end

  always_ff @(posedge cp2) begin
    if (ireset) begin
      sp_q   <= SP_RST;
      sreg_q <= SREG_RST;
    end else begin
      sp_q   <= sp_n;
      sreg_q <= sreg_n;
    end
  end

  always_comb begin
    sp_ext = '0;
    sp_ext[SP_WIDTH-1:0] = sp_q;
  end

  assign spl_out  = sp_ext[7:0];
  assign sph_out  = sp_ext[15:8];
  assign sreg_out = sreg_q;

endmodule

// File: tb/tb_sp_sreg_unit.sv
// Directed testbench for sp_sreg_unit with a queue-based scoreboard.
module tb_sp_sreg_unit;

  logic        cp2 = 1'b0;
  logic        ireset = 1'b1;
  logic [5:0]  adr = '0;
  logic        iowe = 1'b0;
  logic [7:0]  dbusout = '0;
  logic        stk_start = 1'b0;
  logic        stk_dir = 1'b0;
  logic [1:0]  stk_len = '0;
  logic        stk_step = 1'b0;
  logic        stk_busy;
  logic [15:0] stk_adr;
  logic        stk_done;
  logic [7:0]  sreg_fl_in = '0;
  logic [7:0]  sreg_fl_wr = '0;
  logic        irq_ent = 1'b0;
  logic        reti_ex = 1'b0;
  logic [7:0]  spl_out, sph_out, sreg_out;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];

  always #5 cp2 = ~cp2;

  sp_sreg_unit dut (
    .cp2        (cp2),
    .ireset     (ireset),
    .adr        (adr),
    .iowe       (iowe),
    .dbusout    (dbusout),
    .stk_start  (stk_start),
    .stk_dir    (stk_dir),
    .stk_len    (stk_len),
    .stk_step   (stk_step),
    .stk_busy   (stk_busy),
    .stk_adr    (stk_adr),
    .stk_done   (stk_done),
    .sreg_fl_in (sreg_fl_in),
    .sreg_fl_wr (sreg_fl_wr),
    .irq_ent    (irq_ent),
    .reti_ex    (reti_ex),
    .spl_out    (spl_out),
    .sph_out    (sph_out),
    .sreg_out   (sreg_out)
  );

  task automatic tick();
    @(posedge cp2);
    #1;
  endtask

  task automatic expect_val(input logic [15:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs);
    logic [15:0] e;
    #1;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s observed=%h expected=<scoreboard empty>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        fails++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  initial begin
    // Reset and idle
    tick(); tick();
    ireset = 1'b0;
    tick();
    expect_val(16'h00FF); chk("rst_spl",  spl_out);
    expect_val(16'h0008); chk("rst_sph",  sph_out);
    expect_val(16'h0000); chk("rst_sreg", sreg_out);
    expect_val(16'h0000); chk("rst_busy", stk_busy);
    expect_val(16'h0000); chk("rst_done", stk_done);
    expect_val(16'h08FF); chk("idle_adr", stk_adr);

    // Start with len 0 is a no-op
    stk_start = 1'b1; stk_len = 2'd0;
    tick();
    stk_start = 1'b0;
    expect_val(16'h0000); chk("len0_busy", stk_busy);

    // 3-byte push from 0x8FF
    stk_start = 1'b1; stk_len = 2'd3; stk_dir = 1'b0;
    tick();
    stk_start = 1'b0; stk_step = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_val(16'h0001); chk("push_busy", stk_busy);
      expect_val(16'h08FF - 16'(i)); chk("push_adr", stk_adr);
      expect_val(16'h0000); chk("push_nodone", stk_done);
      tick();
    end
    stk_step = 1'b0;
    expect_val(16'h0001); chk("push_done", stk_done);
    expect_val(16'h0000); chk("push_idle", stk_busy);
    expect_val(16'h00FC); chk("push_spl", spl_out);
    expect_val(16'h0008); chk("push_sph", sph_out);
    tick();
    expect_val(16'h0000); chk("push_done_once", stk_done);

    // Load SP = 0xFFF via OUT, then 1-byte pop with a 2-cycle stall
    iowe = 1'b1; adr = 6'h3D; dbusout = 8'hFF;
    tick();
    adr = 6'h3E; dbusout = 8'h0F;
    tick();
    iowe = 1'b0;
    expect_val(16'h00FF); chk("out_spl", spl_out);
    expect_val(16'h000F); chk("out_sph", sph_out);
    stk_start = 1'b1; stk_len = 2'd1; stk_dir = 1'b1;
    tick();
    stk_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      expect_val(16'h0001); chk("stall_busy", stk_busy);
      expect_val(16'h0000); chk("stall_adr", stk_adr);
      tick();
    end
    stk_step = 1'b1;
    expect_val(16'h0000); chk("pop_adr", stk_adr);
    tick();
    stk_step = 1'b0;
    expect_val(16'h0001); chk("pop_done", stk_done);
    expect_val(16'h0000); chk("pop_spl", spl_out);
    expect_val(16'h0000); chk("pop_sph", sph_out);
    tick();

    // SPH write collides with a push step (SP = 0x000)
    stk_start = 1'b1; stk_len = 2'd2; stk_dir = 1'b0;
    tick();
    stk_start = 1'b0;
    stk_step = 1'b1; iowe = 1'b1; adr = 6'h3E; dbusout = 8'hF3;
    tick();
    stk_step = 1'b0; iowe = 1'b0;
    expect_val(16'h0003); chk("coll_sph", sph_out);
    expect_val(16'h0000); chk("coll_spl", spl_out);
    expect_val(16'h0001); chk("coll_busy", stk_busy);
    expect_val(16'h0300); chk("coll_adr", stk_adr);
    stk_step = 1'b1;
    tick();
    stk_step = 1'b0;
    expect_val(16'h0001); chk("coll_done", stk_done);
    expect_val(16'h00FF); chk("coll_spl2", spl_out);
    expect_val(16'h0002); chk("coll_sph2", sph_out);
    tick();

    // SREG priority
    iowe = 1'b1; adr = 6'h3F; dbusout = 8'h5A; irq_ent = 1'b1;
    tick();
    iowe = 1'b0; irq_ent = 1'b0;
    expect_val(16'h005A); chk("sreg_io", sreg_out);
    reti_ex = 1'b1;
    tick();
    expect_val(16'h00DA); chk("sreg_reti", sreg_out);
    irq_ent = 1'b1;
    tick();
    irq_ent = 1'b0; reti_ex = 1'b0;
    expect_val(16'h005A); chk("sreg_irq_reti", sreg_out);
    sreg_fl_wr = 8'h03; sreg_fl_in = 8'hFF;
    tick();
    expect_val(16'h005B); chk("sreg_flags", sreg_out);
    sreg_fl_wr = 8'h90; sreg_fl_in = 8'h00; reti_ex = 1'b1;
    tick();
    sreg_fl_wr = 8'h00; reti_ex = 1'b0;
    expect_val(16'h00CB); chk("sreg_reti_over_fl", sreg_out);

    // Reset during the second step of a 2-byte pop (SP = 0x2FF)
    stk_start = 1'b1; stk_len = 2'd2; stk_dir = 1'b1;
    tick();
    stk_start = 1'b0; stk_step = 1'b1;
    expect_val(16'h0300); chk("rpop_adr", stk_adr);
    tick();
    ireset = 1'b1;
    tick();
    ireset = 1'b0; stk_step = 1'b0;
    expect_val(16'h00FF); chk("mid_rst_spl", spl_out);
    expect_val(16'h0008); chk("mid_rst_sph", sph_out);
    expect_val(16'h0000); chk("mid_rst_busy", stk_busy);
    expect_val(16'h0000); chk("mid_rst_done", stk_done);
    expect_val(16'h0000); chk("mid_rst_sreg", sreg_out);
    tick();
    expect_val(16'h0000); chk("mid_rst_nodone", stk_done);
    expect_val(16'h0000); chk("mid_rst_idle", stk_busy);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
